// File: rtl/add_op_feeder.sv
// Operand sequencer for the 4-bit adder stage: buffers operand pairs, issues them one
// at a time, captures the adder's sum a cycle later and returns results in issue order.
module add_op_feeder #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DW_IN  = 4,
  parameter int unsigned DW_OUT = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW_IN-1:0]  in_a,
  input  logic [DW_IN-1:0]  in_b,
  output logic [DW_IN-1:0]  add_a,
  output logic [DW_IN-1:0]  add_b,
  output logic              add_valid,
  input  logic [DW_OUT-1:0] add_c,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DW_OUT-1:0] res_data,
  output logic              busy,
  output logic [15:0]       ops_done
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned PW     = AW + 1;
  localparam int unsigned PAIR_W = 2 * DW_IN;
  localparam int unsigned OPS_W  = 16;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, HOLD} state_t;

  state_t              state_q, state_d;
  logic [PAIR_W-1:0]   mem_q [DEPTH];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [DW_IN-1:0]    add_a_q, add_a_d;
  logic [DW_IN-1:0]    add_b_q, add_b_d;
  logic                add_valid_q, add_valid_d;
  logic                res_valid_q, res_valid_d;
  logic [DW_OUT-1:0]   res_data_q, res_data_d;
  logic [OPS_W-1:0]    ops_done_q, ops_done_d;
  logic                full_c, empty_c, push_c, pop_c;
  logic [PAIR_W-1:0]   head_c;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full_c  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_c = (wr_ptr_q == rd_ptr_q);
  assign head_c  = mem_q[rd_ptr_q[AW-1:0]];

  assign in_ready = !full_c && !reset;
  assign push_c   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {in_a, in_b};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_valid_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      ops_done_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_valid_q <= add_valid_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      ops_done_q  <= ops_done_d;
    end
  end

  // Sequencer: pop/issue, let the adder sample, capture its sum, hold until accepted.
  always_comb begin
    state_d     = state_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    add_valid_d = 1'b0;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    ops_done_d  = ops_done_q;
    pop_c       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty_c) begin
          pop_c       = 1'b1;
          add_a_d     = head_c[PAIR_W-1:DW_IN];
          add_b_d     = head_c[DW_IN-1:0];
          add_valid_d = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        res_data_d  = add_c;
        res_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          ops_done_d  = ops_done_q + OPS_W'(1);
          if (!empty_c) begin
            pop_c       = 1'b1;
            add_a_d     = head_c[PAIR_W-1:DW_IN];
            add_b_d     = head_c[DW_IN-1:0];
            add_valid_d = 1'b1;
            state_d     = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign wr_ptr_d = wr_ptr_q + PW'(push_c);
  assign rd_ptr_d = rd_ptr_q + PW'(pop_c);

  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_valid = add_valid_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign ops_done  = ops_done_q;
  assign busy      = (state_q != IDLE) || !empty_c;

endmodule

// File: tb/tb_add_op_feeder.sv
// Randomized and directed bench for add_op_feeder with a registered adder model;
// results are checked against an in-order scoreboard of accepted operand pairs.
module tb_add_op_feeder;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned DW_IN  = 4;
  localparam int unsigned DW_OUT = 7;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [DW_IN-1:0]  in_a, in_b;
  logic [DW_IN-1:0]  add_a, add_b;
  logic              add_valid;
  logic [DW_OUT-1:0] add_c;
  logic              res_valid, res_ready;
  logic [DW_OUT-1:0] res_data;
  logic              busy;
  logic [15:0]       ops_done;

  add_op_feeder #(.DEPTH(DEPTH), .DW_IN(DW_IN), .DW_OUT(DW_OUT)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .add_a(add_a), .add_b(add_b), .add_valid(add_valid), .add_c(add_c),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .ops_done(ops_done)
  );

  always #5 clk = ~clk;

  // Adder stage: samples a/b when valid, sum appears on c the following cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) add_c <= '0;
    else if (add_valid) add_c <= DW_OUT'(add_a) + DW_OUT'(add_b);
  end

  typedef struct { int a; int b; int t; } op_t;
  typedef struct { int d; int t; } res_t;

  op_t  acc_q[$];
  op_t  iss_q[$];
  res_t res_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   ops_exp = 0;
  int   av_double = 0;
  logic av_prev = 1'b0;
  logic [34:0] outv;

  task automatic clear_obs();
    acc_q.delete();
    iss_q.delete();
    res_q.delete();
    av_double = 0;
    av_prev   = 1'b0;
  endtask

  // Records handshakes decided at the coming edge, then advances to the next negedge.
  task automatic tick();
    if (in_valid && in_ready) acc_q.push_back('{a: int'(in_a), b: int'(in_b), t: cyc});
    if (add_valid) begin
      iss_q.push_back('{a: int'(add_a), b: int'(add_b), t: cyc});
      if (av_prev) av_double++;
    end
    av_prev = add_valid;
    if (res_valid && res_ready) begin
      res_q.push_back('{d: int'(res_data), t: cyc});
      ops_exp = (ops_exp + 1) % 65536;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_results(input int n, input int budget, output bit ok);
    int k = 0;
    while (res_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    ok = (res_q.size() >= n);
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; res_ready = 1'b0; in_a = '0; in_b = '0;
    repeat (2) @(negedge clk);
    outv = {in_ready, add_a, add_b, add_valid, res_valid, res_data, ops_done, busy};
    n_checks++;
    if (outv !== '0) begin
      n_errors++; $display("FAIL reset_outputs got %h want 0", outv);
    end
    reset = 1'b0; ops_exp = 0; cyc = 0; clear_obs();
    #1;
    n_checks++;
    if ({in_ready, busy} !== 2'b10) begin
      n_errors++; $display("FAIL post_reset_ready_busy got %b want 10", {in_ready, busy});
    end
  endtask

  task automatic test_single_op();
    bit ok;
    clear_obs();
    res_ready = 1'b1; in_valid = 1'b1; in_a = 4'd3; in_b = 4'd4;
    tick();
    in_valid = 1'b0;
    wait_results(1, 20, ok);
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL single_timeout got 0 results want 1"); end
    n_checks++;
    if (iss_q.size() !== 1 || av_double !== 0) begin
      n_errors++; $display("FAIL single_issue_count got %0d pulses (%0d long) want 1", iss_q.size(), av_double);
    end
    if (ok && iss_q.size() > 0) begin
      n_checks++;
      if (iss_q[0].a !== 3 || iss_q[0].b !== 4) begin
        n_errors++; $display("FAIL single_operands got %0d,%0d want 3,4", iss_q[0].a, iss_q[0].b);
      end
      n_checks++;
      if (iss_q[0].t - acc_q[0].t !== 2) begin
        n_errors++; $display("FAIL single_issue_latency got %0d want 2", iss_q[0].t - acc_q[0].t);
      end
      n_checks++;
      if (res_q[0].d !== acc_q[0].a + acc_q[0].b) begin
        n_errors++; $display("FAIL single_result got %0d want %0d", res_q[0].d, acc_q[0].a + acc_q[0].b);
      end
      n_checks++;
      if (res_q[0].t - acc_q[0].t !== 4) begin
        n_errors++; $display("FAIL single_result_latency got %0d want 4", res_q[0].t - acc_q[0].t);
      end
    end
    n_checks++;
    if (int'(ops_done) !== ops_exp || ops_exp !== 1) begin
      n_errors++; $display("FAIL single_ops_done got %0d want 1", ops_done);
    end
    n_checks++;
    if (busy !== 1'b0) begin n_errors++; $display("FAIL single_busy got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    int pa[4] = '{15, 0, 9, 1};
    int pb[4] = '{15, 0, 6, 2};
    int want[4] = '{30, 0, 15, 3};
    bit ok;
    clear_obs();
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_a = DW_IN'(pa[i]); in_b = DW_IN'(pb[i]);
      tick();
    end
    in_valid = 1'b0;
    wait_results(4, 40, ok);
    n_checks++;
    if (!ok || acc_q.size() !== 4) begin
      n_errors++; $display("FAIL b2b_count got %0d results %0d accepted want 4", res_q.size(), acc_q.size());
    end
    for (int i = 0; i < res_q.size() && i < 4; i++) begin
      n_checks++;
      if (res_q[i].d !== want[i] || res_q[i].d !== acc_q[i].a + acc_q[i].b) begin
        n_errors++; $display("FAIL b2b_result[%0d] got %0d want %0d", i, res_q[i].d, want[i]);
      end
      if (i > 0) begin
        n_checks++;
        if (res_q[i].t - res_q[i-1].t !== 3) begin
          n_errors++; $display("FAIL b2b_spacing[%0d] got %0d want 3", i, res_q[i].t - res_q[i-1].t);
        end
      end
    end
    n_checks++;
    if (int'(ops_done) !== ops_exp) begin
      n_errors++; $display("FAIL b2b_ops_done got %0d want %0d", ops_done, ops_exp);
    end
  endtask

  task automatic test_full_backpressure();
    bit ok;
    int k;
    clear_obs();
    res_ready = 1'b0; in_valid = 1'b1;
    for (int t = 0; t < 8; t++) begin
      in_a = DW_IN'(acc_q.size() + 1); in_b = DW_IN'(acc_q.size() + 1);
      tick();
    end
    n_checks++;
    if (acc_q.size() !== DEPTH + 1) begin
      n_errors++; $display("FAIL full_accepted got %0d want %0d", acc_q.size(), DEPTH + 1);
    end
    n_checks++;
    if (in_ready !== 1'b0 || iss_q.size() !== 1) begin
      n_errors++; $display("FAIL full_ready_issue got ready=%b issues=%0d want 0,1", in_ready, iss_q.size());
    end
    res_ready = 1'b1;
    k = 0;
    while (acc_q.size() < DEPTH + 2 && k < 20) begin
      in_a = DW_IN'(acc_q.size() + 1); in_b = DW_IN'(acc_q.size() + 1);
      tick(); k++;
    end
    in_valid = 1'b0;
    wait_results(DEPTH + 2, 60, ok);
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL full_timeout got %0d results want %0d", res_q.size(), DEPTH + 2); end
    for (int i = 0; i < res_q.size() && i < acc_q.size(); i++) begin
      n_checks++;
      if (res_q[i].d !== 2 * (i + 1) || res_q[i].d !== acc_q[i].a + acc_q[i].b) begin
        n_errors++; $display("FAIL full_result[%0d] got %0d want %0d", i, res_q[i].d, 2 * (i + 1));
      end
    end
    if (acc_q.size() > DEPTH + 1 && res_q.size() > 0) begin
      n_checks++;
      if (acc_q[DEPTH+1].t !== res_q[0].t + 1) begin
        n_errors++; $display("FAIL full_reaccept_edge got %0d want %0d", acc_q[DEPTH+1].t, res_q[0].t + 1);
      end
    end
  endtask

  task automatic test_push_pop_simul();
    bit ok;
    int k = 0;
    clear_obs();
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_a = DW_IN'($urandom); in_b = DW_IN'($urandom);
      tick();
    end
    in_valid = 1'b0;
    while (res_valid !== 1'b1 && k < 10) begin tick(); k++; end
    in_valid = 1'b1; in_a = DW_IN'($urandom); in_b = DW_IN'($urandom); res_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_results(4, 40, ok);
    n_checks++;
    if (!ok || acc_q.size() !== 4) begin
      n_errors++; $display("FAIL simul_count got %0d results %0d accepted want 4", res_q.size(), acc_q.size());
    end
    if (ok && acc_q.size() == 4) begin
      n_checks++;
      if (acc_q[3].t !== res_q[0].t) begin
        n_errors++; $display("FAIL simul_same_edge got push@%0d pop@%0d want equal", acc_q[3].t, res_q[0].t);
      end
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (res_q[i].d !== acc_q[i].a + acc_q[i].b) begin
          n_errors++; $display("FAIL simul_result[%0d] got %0d want %0d", i, res_q[i].d, acc_q[i].a + acc_q[i].b);
        end
      end
    end
  endtask

  task automatic test_reset_mid_op();
    bit ok;
    clear_obs();
    res_ready = 1'b1;
    in_valid = 1'b1; in_a = 4'd7; in_b = 4'd8; tick();
    in_a = DW_IN'($urandom); in_b = DW_IN'($urandom); tick();
    in_a = DW_IN'($urandom); in_b = DW_IN'($urandom); tick();
    in_valid = 1'b0;
    n_checks++;
    if (iss_q.size() !== 1 || add_valid !== 1'b0 || res_valid !== 1'b0) begin
      n_errors++; $display("FAIL midreset_capture_phase got issues=%0d av=%b rv=%b want 1,0,0", iss_q.size(), add_valid, res_valid);
    end
    reset = 1'b1;
    #1;
    outv = {in_ready, add_a, add_b, add_valid, res_valid, res_data, ops_done, busy};
    n_checks++;
    if (outv !== '0) begin
      n_errors++; $display("FAIL midreset_outputs got %h want 0", outv);
    end
    @(negedge clk); @(negedge clk);
    reset = 1'b0; ops_exp = 0; clear_obs();
    repeat (10) tick();
    n_checks++;
    if (res_q.size() !== 0 || iss_q.size() !== 0 || ops_done !== 16'd0) begin
      n_errors++; $display("FAIL midreset_stale got results=%0d issues=%0d ops=%0d want 0,0,0", res_q.size(), iss_q.size(), ops_done);
    end
    in_valid = 1'b1; in_a = 4'd2; in_b = 4'd2; tick();
    in_valid = 1'b0;
    wait_results(1, 20, ok);
    n_checks++;
    if (!ok || res_q[0].d !== 4) begin
      n_errors++; $display("FAIL midreset_new_op got %0d results want one result of 4", res_q.size());
    end
  endtask

  task automatic test_random();
    bit ok;
    int max_out = 0;
    clear_obs();
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_a      = DW_IN'($urandom);
      in_b      = DW_IN'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      tick();
      if (acc_q.size() - res_q.size() > max_out) max_out = acc_q.size() - res_q.size();
    end
    in_valid = 1'b0; res_ready = 1'b1;
    wait_results(acc_q.size(), 200, ok);
    n_checks++;
    if (!ok || res_q.size() !== acc_q.size() || iss_q.size() !== acc_q.size()) begin
      n_errors++; $display("FAIL rand_count got res=%0d iss=%0d want %0d", res_q.size(), iss_q.size(), acc_q.size());
    end
    for (int i = 0; i < res_q.size() && i < acc_q.size() && i < iss_q.size(); i++) begin
      n_checks++;
      if (res_q[i].d !== acc_q[i].a + acc_q[i].b || iss_q[i].a !== acc_q[i].a || iss_q[i].b !== acc_q[i].b) begin
        n_errors++; $display("FAIL rand_item[%0d] got %0d (%0d,%0d) want %0d (%0d,%0d)", i, res_q[i].d,
                             iss_q[i].a, iss_q[i].b, acc_q[i].a + acc_q[i].b, acc_q[i].a, acc_q[i].b);
      end
    end
    n_checks++;
    if (max_out > DEPTH + 1 || av_double !== 0) begin
      n_errors++; $display("FAIL rand_capacity got outstanding=%0d long_pulses=%0d want <=%0d,0", max_out, av_double, DEPTH + 1);
    end
    n_checks++;
    if (int'(ops_done) !== ops_exp) begin
      n_errors++; $display("FAIL rand_ops_done got %0d want %0d", ops_done, ops_exp);
    end
  endtask

  task automatic test_counter_wrap();
    bit ok;
    clear_obs();
    res_ready = 1'b1; in_valid = 1'b0;
    force dut.ops_done_q = 16'hFFFF;
    tick();
    release dut.ops_done_q;
    ops_exp = 65535;
    tick();
    n_checks++;
    if (ops_done !== 16'hFFFF) begin
      n_errors++; $display("FAIL wrap_preload got %0d want 65535", ops_done);
    end
    in_valid = 1'b1; in_a = 4'd5; in_b = 4'd6; tick();
    in_valid = 1'b0;
    wait_results(1, 20, ok);
    n_checks++;
    if (!ok || res_q[0].d !== 11) begin
      n_errors++; $display("FAIL wrap_result got %0d results want one result of 11", res_q.size());
    end
    n_checks++;
    if (int'(ops_done) !== ops_exp || ops_exp !== 0) begin
      n_errors++; $display("FAIL wrap_ops_done got %0d want 0", ops_done);
    end
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_back_to_back();
    test_full_backpressure();
    test_push_pop_simul();
    test_reset_mid_op();
    test_random();
    test_counter_wrap();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule
